sysid_reader: RTL and testbench

SYSID_READER -- requirements
Module: sysid_reader

---
 rtl/sysid_reader_pkg.sv | 29 ++
 rtl/sysid_reader_if.sv | 19 +
 rtl/sysid_timeout_ctr.sv | 42 ++++
 rtl/sysid_reader.sv | 151 +++++++++++++++
 tb/tb_sysid_reader.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system-ID reader: FSM state encoding,
// Avalon word addresses and the timeout counter width.
package sysid_reader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    FINISH  = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int unsigned SYSID_CTR_W = 16;

  // True while a read is being requested or awaited.
  function automatic logic sysid_in_pair(input sysid_state_e s);
    logic r;
    case (s)
      ID_REQ, ID_WAIT, TS_REQ, TS_WAIT: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sysid_reader_if.sv
// Avalon-MM read-only bus between the system-ID reader (master) and the
// system-ID peripheral (slave).
interface sysid_reader_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sysid_timeout_ctr.sv
// Saturating cycle counter; expired is high once LIMIT cycles of enable have
// elapsed since the last clear. Only built with SYSID_READER_TIMEOUT_EN.
module sysid_timeout_ctr
  import sysid_reader_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [SYSID_CTR_W-1:0] LIMIT_C = SYSID_CTR_W'(LIMIT);

  logic [SYSID_CTR_W-1:0] count_q, count_d;

  // Next count: clear wins, then count up and hold at the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT_C)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT_C);

endmodule

// File: rtl/sysid_reader.sv
// Reads the system ID (address 0) and build timestamp (address 1) over
// Avalon-MM and compares them; optional per-read timeout via SYSID_READER_TIMEOUT_EN.
module sysid_reader
  import sysid_reader_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1476908497,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  sysid_reader_if.master avm,
  output logic           busy,
  output logic           done,
  output logic           id_ok,
  output logic           ts_ok,
  output logic [31:0]    id_value,
  output logic [31:0]    ts_value,
  output logic           timeout
);

  if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_cfg
    $error("sysid_reader: TIMEOUT_CYCLES must be in 1..65535");
  end

  sysid_state_e state_q, state_d;
  logic         id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
  logic [31:0]  id_value_q, id_value_d, ts_value_q, ts_value_d;
  logic         pair_s, id_cap_s, ts_cap_s, tmo_hit_s, expired_s;

  // Data is accepted in the request cycle itself (zero-latency slave) or while waiting.
  always_comb begin
    pair_s    = sysid_in_pair(state_q);
    id_cap_s  = avm.avm_readdatavalid &&
                (((state_q == ID_REQ) && !avm.avm_waitrequest) || (state_q == ID_WAIT));
    ts_cap_s  = avm.avm_readdatavalid &&
                (((state_q == TS_REQ) && !avm.avm_waitrequest) || (state_q == TS_WAIT));
    tmo_hit_s = expired_s && pair_s && !id_cap_s && !ts_cap_s;
  end

`ifdef SYSID_READER_TIMEOUT_EN
  logic ctr_clear_s;
  assign ctr_clear_s = !pair_s || id_cap_s || ts_cap_s;

  sysid_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ctr_clear_s),
    .enable  (pair_s),
    .expired (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ID_REQ; else state_d = IDLE;
      ID_REQ:  if (id_cap_s) state_d = TS_REQ;
               else if (tmo_hit_s) state_d = FINISH;
               else if (!avm.avm_waitrequest) state_d = ID_WAIT;
               else state_d = ID_REQ;
      ID_WAIT: if (id_cap_s) state_d = TS_REQ;
               else if (tmo_hit_s) state_d = FINISH;
               else state_d = ID_WAIT;
      TS_REQ:  if (ts_cap_s || tmo_hit_s) state_d = FINISH;
               else if (!avm.avm_waitrequest) state_d = TS_WAIT;
               else state_d = TS_REQ;
      TS_WAIT: if (ts_cap_s || tmo_hit_s) state_d = FINISH; else state_d = TS_WAIT;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    avm.avm_read    = 1'b0;
    avm.avm_address = SYSID_ADDR_ID;
    busy            = (state_q != IDLE);
    done            = 1'b0;
    case (state_q)
      ID_REQ:  avm.avm_read = 1'b1;
      TS_REQ:  begin
        avm.avm_read    = 1'b1;
        avm.avm_address = SYSID_ADDR_TS;
      end
      FINISH:  done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // Result capture; a new sequence clears the flags but keeps the last values.
  always_comb begin
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    if ((state_q == IDLE) && start) begin
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;
    end else if (id_cap_s) begin
      id_value_d = avm.avm_readdata;
      id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
    end else if (ts_cap_s) begin
      ts_value_d = avm.avm_readdata;
      ts_ok_d    = (avm.avm_readdata == EXPECTED_TS);
    end else if (tmo_hit_s) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader with a configurable Avalon slave model
// (waitrequest stall on the ID read, readdatavalid latency, silent slave, stray data).
module tb_sysid_reader;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1476908497;
  localparam logic [31:0] TS_BAD = 32'd1476908496;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int total = 0;
  int bad   = 0;

  int          cfg_stall = 0;
  int          lat = 0;
  bit          never_valid = 1'b0;
  bit          stray = 1'b0;
  logic [31:0] data_id = 32'd0;
  logic [31:0] data_ts = 32'd0;
  logic [31:0] stray_data = 32'd0;

  bit   pend = 1'b0;
  int   pend_cnt = 0;
  logic pend_addr = 1'b0;
  int   stall_cnt = 0;
  logic acc_s;

  sysid_reader_if avm_if ();

  sysid_reader #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .avm      (avm_if),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .id_value (id_value),
    .ts_value (ts_value),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  // Slave model: stalls only the ID read, returns data after lat cycles (0 = same cycle).
  assign avm_if.avm_waitrequest = avm_if.avm_read && (avm_if.avm_address == 1'b0) &&
                                  (stall_cnt < cfg_stall);
  assign acc_s = avm_if.avm_read && !avm_if.avm_waitrequest;

  always_comb begin
    avm_if.avm_readdatavalid = 1'b0;
    avm_if.avm_readdata      = 32'd0;
    if (stray) begin
      avm_if.avm_readdatavalid = 1'b1;
      avm_if.avm_readdata      = stray_data;
    end else if (!never_valid && acc_s && (lat == 0)) begin
      avm_if.avm_readdatavalid = 1'b1;
      avm_if.avm_readdata      = avm_if.avm_address ? data_ts : data_id;
    end else if (!never_valid && pend && (pend_cnt == 0)) begin
      avm_if.avm_readdatavalid = 1'b1;
      avm_if.avm_readdata      = pend_addr ? data_ts : data_id;
    end
  end

  always @(posedge clock) begin
    if (avm_if.avm_read && (avm_if.avm_address == 1'b0) && avm_if.avm_waitrequest)
      stall_cnt <= stall_cnt + 1;
    else if (!(avm_if.avm_read && (avm_if.avm_address == 1'b0)))
      stall_cnt <= 0;
    if (acc_s && (lat > 0)) begin
      pend      <= 1'b1;
      pend_cnt  <= lat - 1;
      pend_addr <= avm_if.avm_address;
    end else if (pend) begin
      if (pend_cnt == 0) pend <= 1'b0;
      else pend_cnt <= pend_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_slave(input int st, input int lt, input bit nv,
                           input logic [31:0] did, input logic [31:0] dts);
    cfg_stall   = st;
    lat         = lt;
    never_valid = nv;
    data_id     = did;
    data_ts     = dts;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && (n < budget)) begin
      tick();
      n++;
    end
    if (!done) n = -1;
  endtask

  // Cycles from the start edge to the first cycle with done high (-1 if never).
  task automatic run_seq(input int budget, output int cyc);
    int n;
    pulse_start();
    wait_done(budget, n);
    cyc = (n < 0) ? -1 : n + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, n, dones;
    bit  stable;
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) tick();
    check_eq("rst_flags", {busy, done, avm_if.avm_read, avm_if.avm_address, id_ok, ts_ok, timeout}, 32'd0);
    check_eq("rst_id_value", id_value, 32'd0);
    check_eq("rst_ts_value", ts_value, 32'd0);
    reset_n = 1'b1;
    tick();

    // Zero-latency slave
    set_slave(0, 0, 1'b0, EXP_ID, EXP_TS);
    run_seq(40, cyc);
    check_eq("zl_cycles", cyc, 32'd3);
    check_eq("zl_ok", {id_ok, ts_ok}, 32'd3);
    check_eq("zl_ts_value", ts_value, 32'd1476908497);
    check_eq("zl_id_value", id_value, 32'd0);
    tick();
    check_eq("zl_done_pulse", {done, busy}, 32'd0);

    // Four-cycle waitrequest on the ID read
    set_slave(4, 0, 1'b0, EXP_ID, EXP_TS);
    pulse_start();
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stable &= avm_if.avm_read && (avm_if.avm_address == 1'b0) && avm_if.avm_waitrequest;
      tick();
    end
    check_eq("stall_stable", stable, 32'd1);
    wait_done(40, n);
    check_eq("stall_tail", n, 32'd2);
    check_eq("stall_ok", {id_ok, ts_ok}, 32'd3);
    tick();

    // readdatavalid three cycles after acceptance, wrong timestamp
    set_slave(0, 3, 1'b0, EXP_ID, 32'hDEADBEEF);
    run_seq(40, cyc);
    check_eq("lat3_cycles", cyc, 32'd9);
    check_eq("lat3_ok", {id_ok, ts_ok}, 32'd2);
    check_eq("lat3_ts_value", ts_value, 32'hDEADBEEF);
    tick();

    // MSB-only ID difference; flags cleared on start
    set_slave(0, 0, 1'b0, 32'h8000_0000, EXP_TS);
    pulse_start();
    check_eq("clr_on_start", {id_ok, ts_ok}, 32'd0);
    wait_done(40, n);
    check_eq("msb_ok", {id_ok, ts_ok}, 32'd1);
    check_eq("msb_id_value", id_value, 32'h8000_0000);
    tick();

    // LSB-only timestamp difference
    set_slave(0, 0, 1'b0, EXP_ID, TS_BAD);
    run_seq(40, cyc);
    check_eq("lsb_ok", {id_ok, ts_ok}, 32'd2);
    check_eq("lsb_ts_value", ts_value, TS_BAD);
    tick();

    // start pulses while busy are ignored
    set_slave(0, 3, 1'b0, EXP_ID, EXP_TS);
    pulse_start();
    dones = 0;
    for (int k = 1; k <= 25; k++) begin
      if ((k == 2) || (k == 4) || (k == 7)) start = 1'b1;
      tick();
      start = 1'b0;
      if (done) dones++;
    end
    check_eq("busy_dones", dones, 32'd1);
    check_eq("busy_idle", busy, 32'd0);

    // Reset in TS_WAIT, late and stray readdatavalid, then recovery
    set_slave(0, 3, 1'b0, EXP_ID, EXP_TS);
    pulse_start();
    repeat (5) tick();
    check_eq("mid_state", {busy, id_ok, avm_if.avm_read}, 32'd6);
    reset_n = 1'b0;
    #1;
    check_eq("rst_async", {busy, done, avm_if.avm_read, id_ok, ts_ok, timeout}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check_eq("late_rdv", {busy, ts_ok}, 32'd0);
    check_eq("late_ts_value", ts_value, 32'd0);
    stray      = 1'b1;
    stray_data = 32'h1234_5678;
    tick();
    stray = 1'b0;
    check_eq("stray_values", id_value | ts_value, 32'd0);
    set_slave(0, 0, 1'b0, EXP_ID, EXP_TS);
    run_seq(40, cyc);
    check_eq("post_rst_cycles", cyc, 32'd3);
    check_eq("post_rst_ts", ts_value, EXP_TS);
    tick();

`ifdef SYSID_READER_TIMEOUT_EN
    // Silent slave with TIMEOUT_CYCLES=8
    set_slave(0, 0, 1'b1, EXP_ID, EXP_TS);
    run_seq(40, cyc);
    check_eq("to_window", (cyc >= 8) && (cyc <= 11), 32'd1);
    check_eq("to_flags", {timeout, id_ok, ts_ok}, 32'd4);
    tick();
    check_eq("to_idle", {busy, avm_if.avm_read}, 32'd0);
    set_slave(0, 0, 1'b0, EXP_ID, EXP_TS);
    pulse_start();
    check_eq("to_cleared", timeout, 32'd0);
    wait_done(40, n);
    check_eq("to_recover", {id_ok, ts_ok, timeout}, 32'd6);
    tick();
`else
    // Silent slave waits indefinitely without a timeout
    set_slave(0, 0, 1'b1, EXP_ID, EXP_TS);
    pulse_start();
    repeat (20) tick();
    check_eq("hang_busy", {busy, done, timeout}, 32'd4);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("hang_reset", busy, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
